// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/framing checks and a
// first-word-fall-through frame FIFO toward the host side.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_50m,
   input  logic                          rst_n,
   input  logic                          clken,
   input  logic                          Rx,
   input  logic                          rd_en,
   input  logic                          overrun_clr,
   output logic                          valid,
   output logic [DATA_BITS-1:0]          data,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_BITS + 2;
   localparam logic [SW-1:0] VOTE_A   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] VOTE_B   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] VOTE_C   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] LAST_S   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUSH} state_t;

   state_t                stateQ, stateD;
   logic                  rxMetaQ, rxsQ;
   logic [SW-1:0]         sampleQ, sampleD;
   logic [BW-1:0]         bitCntQ, bitCntD;
   logic                  stopCntQ, stopCntD;
   logic                  voteAQ, voteAD, voteBQ, voteBD;
   logic [DATA_BITS-1:0]  scratchQ, scratchD;
   logic                  parityErrQ, parityErrD;
   logic                  frameErrQ, frameErrD;
   logic [AW:0]           wrPtrQ, rdPtrQ;
   logic                  overrunQ, overrunD;
   logic [EW-1:0]         mem [FIFO_DEPTH];

   logic                  atVoteA, atVoteB, atVoteC, bitEnd, voteBit;
   logic                  pushReq, full, pop, wrEn;
   logic [EW-1:0]         head;

   assign atVoteA = clken && (sampleQ == VOTE_A);
   assign atVoteB = clken && (sampleQ == VOTE_B);
   assign atVoteC = clken && (sampleQ == VOTE_C);
   assign bitEnd  = clken && (sampleQ == LAST_S);
   // The third sample is the live synchronised value at the last vote tick.
   assign voteBit = (voteAQ & voteBQ) | (voteAQ & rxsQ) | (voteBQ & rxsQ);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rxMetaQ    <= 1'b1;
         rxsQ       <= 1'b1;
         stateQ     <= S_IDLE;
         sampleQ    <= '0;
         bitCntQ    <= '0;
         stopCntQ   <= 1'b0;
         voteAQ     <= 1'b0;
         voteBQ     <= 1'b0;
         scratchQ   <= '0;
         parityErrQ <= 1'b0;
         frameErrQ  <= 1'b0;
         wrPtrQ     <= '0;
         rdPtrQ     <= '0;
         overrunQ   <= 1'b0;
      end else begin
         rxMetaQ    <= Rx;
         rxsQ       <= rxMetaQ;
         stateQ     <= stateD;
         sampleQ    <= sampleD;
         bitCntQ    <= bitCntD;
         stopCntQ   <= stopCntD;
         voteAQ     <= voteAD;
         voteBQ     <= voteBD;
         scratchQ   <= scratchD;
         parityErrQ <= parityErrD;
         frameErrQ  <= frameErrD;
         overrunQ   <= overrunD;
         if (wrEn) wrPtrQ <= wrPtrQ + 1'b1;
         if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      end
   end

   always_comb begin
      stateD     = stateQ;
      sampleD    = sampleQ;
      bitCntD    = bitCntQ;
      stopCntD   = stopCntQ;
      voteAD     = atVoteA ? rxsQ : voteAQ;
      voteBD     = atVoteB ? rxsQ : voteBQ;
      scratchD   = scratchQ;
      parityErrD = parityErrQ;
      frameErrD  = frameErrQ;
      if (clken && stateQ != S_IDLE && stateQ != S_PUSH)
         sampleD = bitEnd ? '0 : sampleQ + 1'b1;
      case (stateQ)
         S_IDLE: begin
            if (clken && !rxsQ) begin
               stateD     = S_START;
               sampleD    = '0;
               parityErrD = 1'b0;
               frameErrD  = 1'b0;
            end
         end
         S_START: begin
            if (atVoteC && voteBit) begin
               stateD = S_IDLE;
            end else if (bitEnd) begin
               stateD  = S_DATA;
               bitCntD = '0;
            end
         end
         S_DATA: begin
            if (atVoteC) scratchD[bitCntQ] = voteBit;
            if (bitEnd) begin
               bitCntD  = bitCntQ + 1'b1;
               stopCntD = 1'b0;
               if (bitCntQ == LAST_BIT) stateD = (PARITY != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (atVoteC)
               parityErrD = (PARITY == 1) ? ~(^scratchQ ^ voteBit) : (^scratchQ ^ voteBit);
            if (bitEnd) begin
               stateD   = S_STOP;
               stopCntD = 1'b0;
            end
         end
         S_STOP: begin
            // The final stop bit leaves at its last vote so baud drift cannot eat the next start bit.
            if (atVoteC) begin
               if (!voteBit) frameErrD = 1'b1;
               if (stopCntQ == 1'(STOP_BITS - 1)) stateD = S_PUSH;
            end else if (bitEnd) begin
               stopCntD = stopCntQ + 1'b1;
            end
         end
         S_PUSH:  stateD = S_IDLE;
         default: stateD = S_IDLE;
      endcase
   end

   always_comb begin
      pushReq = (stateQ == S_PUSH);
   end

   assign level = wrPtrQ - rdPtrQ;
   assign valid = (wrPtrQ != rdPtrQ);
   assign full  = (level == (AW + 1)'(FIFO_DEPTH));
   assign pop   = rd_en && valid;
   assign wrEn  = pushReq && (!full || pop);
   assign head  = mem[rdPtrQ[AW-1:0]];

   always_comb begin
      overrunD = overrunQ;
      if (overrun_clr) overrunD = 1'b0;
      if (pushReq && full && !pop) overrunD = 1'b1;
   end

   always_ff @(posedge clk_50m) begin
      if (wrEn) mem[wrPtrQ[AW-1:0]] <= {frameErrQ, parityErrQ, scratchQ};
   end

   // Head is gated by valid so an empty FIFO presents all-zero outputs.
   assign data       = valid ? head[DATA_BITS-1:0] : '0;
   assign parity_err = valid & head[DATA_BITS];
   assign frame_err  = valid & head[DATA_BITS+1];
   assign overrun    = overrunQ;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: three instances (8N1, 8E1, 9N2) driven by
// directed frames; a negedge monitor pops FIFO entries and checks them in order.
module tb_uart_rx_fifo;

   localparam int OS = 16;

   typedef struct {
      int          dut;
      logic [10:0] word;
   } exp_t;

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b0;
   logic clken   = 1'b0;
   logic overrun_clr = 1'b0;
   logic rxLine  [3];
   logic rdEn    [3];
   logic drainEn [3];

   logic       v0, pe0, fe0, ov0;
   logic [7:0] d0;
   logic [2:0] lv0;
   logic       v1, pe1, fe1, ov1;
   logic [7:0] d1;
   logic [2:0] lv1;
   logic       v2, pe2, fe2, ov2;
   logic [8:0] d2;
   logic [2:0] lv2;

   logic        validA [3];
   logic [10:0] headA  [3];

   exp_t expQ [$];
   exp_t monE;
   int   checks = 0;
   int   fails  = 0;
   int   divCnt = 0;

   uart_rx_fifo dut0 (
      .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .Rx(rxLine[0]), .rd_en(rdEn[0]),
      .overrun_clr(overrun_clr), .valid(v0), .data(d0), .parity_err(pe0),
      .frame_err(fe0), .overrun(ov0), .level(lv0));

   uart_rx_fifo #(.PARITY(2)) dut1 (
      .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .Rx(rxLine[1]), .rd_en(rdEn[1]),
      .overrun_clr(overrun_clr), .valid(v1), .data(d1), .parity_err(pe1),
      .frame_err(fe1), .overrun(ov1), .level(lv1));

   uart_rx_fifo #(.DATA_BITS(9), .STOP_BITS(2)) dut2 (
      .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .Rx(rxLine[2]), .rd_en(rdEn[2]),
      .overrun_clr(overrun_clr), .valid(v2), .data(d2), .parity_err(pe2),
      .frame_err(fe2), .overrun(ov2), .level(lv2));

   assign validA[0] = v0;
   assign validA[1] = v1;
   assign validA[2] = v2;
   assign headA[0]  = {fe0, pe0, 1'b0, d0};
   assign headA[1]  = {fe1, pe1, 1'b0, d1};
   assign headA[2]  = {fe2, pe2, d2};

   always #5 clk_50m = ~clk_50m;

   // Oversample tick every 4 clocks, changed on the falling edge so it is stable at the rising edge.
   always @(negedge clk_50m) begin
      clken  = (divCnt == 0);
      divCnt = (divCnt + 1) % 4;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_50m) begin
      for (int d = 0; d < 3; d++) begin
         rdEn[d] = 1'b0;
         if (rst_n && drainEn[d] && validA[d]) begin
            if (expQ.size() == 0 || expQ[0].dut != d) begin
               checks++;
               fails++;
               $display("[TB] FAIL dut%0d_unexpected: got %0h, expected no entry", d, headA[d]);
            end else begin
               monE = expQ.pop_front();
               checkOutput($sformatf("dut%0d_entry", d), 32'(headA[d]), 32'(monE.word));
            end
            rdEn[d] = 1'b1;
         end
      end
   end

   task automatic pushExp(input int d, input logic [10:0] w);
      exp_t e;
      e.dut  = d;
      e.word = w;
      expQ.push_back(e);
   endtask

   task automatic waitTicks(input int n);
      repeat (n) begin
         @(posedge clk_50m);
         while (!clken) @(posedge clk_50m);
      end
   endtask

   task automatic sendBit(input int d, input logic b);
      rxLine[d] = b;
      waitTicks(OS);
   endtask

   // parBit < 0 means no parity bit on the line.
   task automatic applyStimulus(input int d, input logic [8:0] payload, input int nBits,
                                input int parBit, input logic stopVal, input int nStop);
      sendBit(d, 1'b0);
      for (int i = 0; i < nBits; i++) sendBit(d, payload[i]);
      if (parBit >= 0) sendBit(d, parBit[0]);
      sendBit(d, stopVal);
      for (int i = 1; i < nStop; i++) sendBit(d, 1'b1);
      rxLine[d] = 1'b1;
      waitTicks(OS);
   endtask

   task automatic waitDrain(input int d, input string name);
      int n = 0;
      while ((expQ.size() != 0 || validA[d]) && n < 3000) begin
         @(posedge clk_50m);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         fails++;
         $display("[TB] FAIL %s_timeout: got %0d pending, expected 0", name, expQ.size());
      end
      @(negedge clk_50m);
      checkOutput({name, "_empty"}, 32'(validA[d]), 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rxLine[d]  = 1'b1;
         rdEn[d]    = 1'b0;
         drainEn[d] = 1'b1;
      end
      repeat (4) @(negedge clk_50m);
      checkOutput("rst_valid", 32'(v0), 32'd0);
      checkOutput("rst_data", 32'(d0), 32'd0);
      checkOutput("rst_perr", 32'(pe0), 32'd0);
      checkOutput("rst_ferr", 32'(fe0), 32'd0);
      checkOutput("rst_overrun", 32'(ov0), 32'd0);
      checkOutput("rst_level", 32'(lv0), 32'd0);
      rst_n = 1'b1;
      waitTicks(4);

      // 8N1 0xA5, held until checked, then drained.
      drainEn[0] = 1'b0;
      applyStimulus(0, 9'h0A5, 8, -1, 1'b1, 1);
      @(negedge clk_50m);
      checkOutput("t1_valid", 32'(v0), 32'd1);
      checkOutput("t1_level", 32'(lv0), 32'd1);
      pushExp(0, {2'b00, 9'h0A5});
      drainEn[0] = 1'b1;
      waitDrain(0, "t1");

      // Even parity: 0x03 has even weight, so parity bit 1 is an error.
      pushExp(1, {2'b01, 9'h003});
      applyStimulus(1, 9'h003, 8, 1, 1'b1, 1);
      pushExp(1, {2'b00, 9'h003});
      applyStimulus(1, 9'h003, 8, 0, 1'b1, 1);
      waitDrain(1, "t2");

      pushExp(0, {2'b10, 9'h05A});
      applyStimulus(0, 9'h05A, 8, -1, 1'b0, 1);
      waitDrain(0, "t3");

      rxLine[0] = 1'b0;
      waitTicks(3);
      rxLine[0] = 1'b1;
      waitTicks(2 * OS);
      checkOutput("t4_nopush", 32'(v0), 32'd0);
      pushExp(0, {2'b00, 9'h011});
      applyStimulus(0, 9'h011, 8, -1, 1'b1, 1);
      waitDrain(0, "t4");

      drainEn[0] = 1'b0;
      for (int i = 1; i <= 5; i++) applyStimulus(0, 9'(i), 8, -1, 1'b1, 1);
      @(negedge clk_50m);
      checkOutput("t5_level", 32'(lv0), 32'd4);
      checkOutput("t5_overrun", 32'(ov0), 32'd1);
      for (int i = 1; i <= 4; i++) pushExp(0, {2'b00, 9'(i)});
      drainEn[0] = 1'b1;
      waitDrain(0, "t5");
      checkOutput("t5_sticky", 32'(ov0), 32'd1);
      overrun_clr = 1'b1;
      @(negedge clk_50m);
      overrun_clr = 1'b0;
      @(negedge clk_50m);
      checkOutput("t5_clear", 32'(ov0), 32'd0);

      // Abandon 0x77 after three data bits.
      sendBit(0, 1'b0);
      for (int i = 0; i < 3; i++) sendBit(0, 1'b1);
      rst_n = 1'b0;
      repeat (3) @(negedge clk_50m);
      checkOutput("t6_rst_valid", 32'(v0), 32'd0);
      checkOutput("t6_rst_level", 32'(lv0), 32'd0);
      checkOutput("t6_rst_data", 32'(d0), 32'd0);
      rxLine[0] = 1'b1;
      repeat (3) @(negedge clk_50m);
      rst_n = 1'b1;
      waitTicks(2 * OS);
      checkOutput("t6_noentry", 32'(v0), 32'd0);
      pushExp(0, {2'b00, 9'h03C});
      applyStimulus(0, 9'h03C, 8, -1, 1'b1, 1);
      waitDrain(0, "t6");

      pushExp(2, {2'b00, 9'h1FF});
      applyStimulus(2, 9'h1FF, 9, -1, 1'b1, 2);
      waitDrain(2, "t6b");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
